fifo_spad_loader: RTL

FIFO_SPAD_LOADER -- requirements
Module: fifo_spad_loader

---
 rtl/fifo_spad_loader_pkg.sv | 14 +
 rtl/fifo_spad_loader_addr_counter.sv | 34 +++
 rtl/fifo_spad_loader.sv | 105 ++++++++++
 3 files changed

// File: rtl/fifo_spad_loader_pkg.sv
// Shared definitions for the FIFO-to-scratchpad loader: FSM encoding and default widths.
package fifo_spad_loader_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_ADDR_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/fifo_spad_loader_addr_counter.sv
// Scratchpad write-address generator: latches the burst base, counts completed writes,
// and produces base+written wrapped to ADDR_WIDTH bits.
module spad_addr_counter
   import fifo_spad_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic                  inc,
   input  logic [ADDR_WIDTH-1:0] base,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [ADDR_WIDTH:0]   written
);

   logic [ADDR_WIDTH-1:0] base_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q  <= '0;
         written <= '0;
      end else if (load) begin
         base_q  <= base;
         written <= '0;
      end else if (inc) begin
         written <= written + 1'b1;
      end
   end

   // Only the low bits feed the address, so the sum wraps naturally.
   assign addr = base_q + written[ADDR_WIDTH-1:0];

endmodule

// File: rtl/fifo_spad_loader.sv
// Pops a burst of words from an upstream FIFO and writes them to consecutive scratchpad
// addresses; FIFO data arrives one cycle after each pop and is written in that cycle.
//
// state | meaning
// IDLE  | waiting for start; load_count/base_addr captured on accept
// LOAD  | issuing FIFO pops while not empty and issued < count
// DRAIN | last pop issued, waiting for its data to be written
// DONE  | one-cycle done pulse, start ignored
module fifo_spad_loader
   import fifo_spad_loader_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   load_count,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   output logic                  fifo_read_request,
   output logic                  spad_we,
   output logic [ADDR_WIDTH-1:0] spad_waddr,
   output logic [DATA_WIDTH-1:0] spad_wdata,
   output logic                  busy,
   output logic                  done
);

   state_t                state, state_next;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH:0]   issued;
   logic [ADDR_WIDTH:0]   written;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  rd_valid;
   logic                  rd_req;
   logic                  accept;
   logic                  last_issue;
   logic                  last_write;

   assign last_issue = (issued + 1'b1) == count_q;
   assign last_write = rd_valid && ((written + 1'b1) == count_q);

   always_comb begin
      state_next = state;
      rd_req     = 1'b0;
      accept     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = (load_count == '0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            rd_req = !fifo_empty && (issued < count_q);
            if (rd_req && last_issue) state_next = DRAIN;
         end
         DRAIN: begin
            if (last_write) state_next = DONE;
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         count_q  <= '0;
         issued   <= '0;
         rd_valid <= 1'b0;
      end else begin
         state    <= state_next;
         rd_valid <= rd_req;
         if (accept) begin
            count_q <= load_count;
            issued  <= '0;
         end else if (rd_req) begin
            issued <= issued + 1'b1;
         end
      end
   end

   spad_addr_counter #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_addr_counter (
      .clk     (clk),
      .reset   (reset),
      .load    (accept),
      .inc     (rd_valid),
      .base    (base_addr),
      .addr    (wr_addr),
      .written (written)
   );

   // Write-side outputs are held at zero outside write cycles so nothing stale leaks out.
   assign fifo_read_request = rd_req;
   assign spad_we           = rd_valid;
   assign spad_waddr        = rd_valid ? wr_addr : '0;
   assign spad_wdata        = rd_valid ? fifo_rd_data : '0;
   assign busy              = (state != IDLE);
   assign done              = (state == DONE);

endmodule
